test_result_monitor: RTL

Synthesizable self-check monitor for the MIPS core. It snoops the data-memory write port, keeps a programmable table of up to N_CHECKS (address, expected value) pairs, and waits for a "test done" store. It then scores every table entry against the last value written there and reports pass/fail, the fail count, the first failing entry and timeout. It replaces per-test hand-written bench checks (single fixed address, single value, no timeout) and sits beside the data RAM in the core or in any top-level bench.

---
 rtl/test_result_monitor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/test_result_monitor.sv
// test_result_monitor: snoops data-memory stores, scores a table of expected values after a done store.
// Define TEST_MON_TRACE_EN for simulation-only per-entry and final-result messages.
module test_result_monitor #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                N_CHECKS    = 4,
  parameter logic [ADDR_W-1:0] DONE_ADDR   = '0,
  parameter int                TIMEOUT_CYC = 100000,
  parameter int                IDX_W       = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_cfg_we,
  input  logic [IDX_W-1:0]  i_cfg_idx,
  input  logic              i_cfg_en,
  input  logic [ADDR_W-1:0] i_cfg_addr,
  input  logic [DATA_W-1:0] i_cfg_data,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [IDX_W:0]    o_fail_cnt,
  output logic [IDX_W-1:0]  o_first_fail
);

  // state  | meaning
  // IDLE   | table writable, waiting for start
  // RUN    | capturing stores to tracked addresses, timeout running
  // CHECK  | scoring one table entry per cycle
  // DONE   | results held, table writable, start re-arms
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int                TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W:0]    N_ENT    = (IDX_W + 1)'(N_CHECKS);

  logic [1:0]          state;
  logic [N_CHECKS-1:0] ent_en;
  logic [N_CHECKS-1:0] ent_wr;
  logic [N_CHECKS-1:0] hit;
  logic [ADDR_W-1:0]   ent_addr [N_CHECKS];
  logic [DATA_W-1:0]   ent_exp  [N_CHECKS];
  logic [DATA_W-1:0]   ent_cap  [N_CHECKS];
  logic [TMR_W-1:0]    tmr;
  logic [IDX_W:0]      scan;
  logic [IDX_W-1:0]    scan_idx;
  logic                cfg_ok;
  logic                done_store;
  logic                tmr_tc;
  logic                scan_last;
  logic                cur_fail;

  assign cfg_ok     = ((state == S_IDLE) || (state == S_DONE)) && i_cfg_we &&
                      ({1'b0, i_cfg_idx} < N_ENT);
  assign done_store = i_mem_we && (i_mem_addr == DONE_ADDR) && i_mem_wdata[0];
  assign tmr_tc     = (tmr == '0);
  assign scan_idx   = scan[IDX_W-1:0];
  assign scan_last  = (scan == N_ENT);
  assign cur_fail   = !scan_last && ent_en[scan_idx] &&
                      (!ent_wr[scan_idx] || (ent_cap[scan_idx] != ent_exp[scan_idx]));

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CHECKS; i++) begin
      hit[i] = (state == S_RUN) && i_mem_we && ent_en[i] && (ent_addr[i] == i_mem_addr);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      ent_en       <= '0;
      ent_wr       <= '0;
      tmr          <= '0;
      scan         <= '0;
      o_pass       <= 1'b0;
      o_timeout    <= 1'b0;
      o_fail_cnt   <= '0;
      o_first_fail <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (cfg_ok) ent_en[i_cfg_idx] <= i_cfg_en;
          if (i_start) begin
            state        <= S_RUN;
            ent_wr       <= '0;
            tmr          <= TMR_LOAD;
            o_pass       <= 1'b0;
            o_timeout    <= 1'b0;
            o_fail_cnt   <= '0;
            o_first_fail <= '0;
          end
        end
        S_RUN: begin
          ent_wr <= ent_wr | hit;
          // a done store on the terminal-count cycle still gets scored
          if (done_store) begin
            state <= S_CHECK;
            scan  <= '0;
          end else if (tmr_tc) begin
            state     <= S_DONE;
            o_timeout <= 1'b1;
            o_pass    <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_CHECK: begin
          if (scan_last) begin
            state  <= S_DONE;
            o_pass <= (o_fail_cnt == '0);
          end else begin
            if (cur_fail) begin
              o_fail_cnt <= o_fail_cnt + 1'b1;
              if (o_fail_cnt == '0) o_first_fail <= scan_idx;
            end
            scan <= scan + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // table payload needs no reset: only enabled, written entries are ever scored
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N_CHECKS; i++) begin
      if (cfg_ok && (i_cfg_idx == IDX_W'(i))) begin
        ent_addr[i] <= i_cfg_addr;
        ent_exp[i]  <= i_cfg_data;
      end
      if (hit[i]) ent_cap[i] <= i_mem_wdata;
    end
  end

  assign o_busy = (state == S_RUN) || (state == S_CHECK);
  assign o_done = (state == S_DONE);

`ifdef TEST_MON_TRACE_EN
  always @(posedge i_clk) begin
    if (!i_rst && (state == S_CHECK)) begin
      if (cur_fail)
        $display("test_result_monitor: entry %0d addr %h expected %h captured %h%s",
                 scan_idx, ent_addr[scan_idx], ent_exp[scan_idx], ent_cap[scan_idx],
                 ent_wr[scan_idx] ? "" : " (never written)");
      if (scan_last) $display("%s", (o_fail_cnt == '0) ? "SUCCESS" : "ERROR");
    end
    if (!i_rst && (state == S_RUN) && !done_store && tmr_tc) $display("TIMEOUT");
  end
`else
`endif

endmodule
